dmem_arbiter: RTL and testbench
===============================

// Module: dmem_arbiter
// PURPOSE
//  Shares the single-port synchronous data_mem between two requesters: the noobs_cpu data port and a
//  debug/loader port (UART loader, test bench). Sits between the CPU m_* bus and data_mem, replacing
//  the direct hookup and the fixed "m_addr - 8" subtraction.
//  Does per-cycle arbitration, anti-starvation counting, locked debug bursts and read-data return routing.
// PARAMETERS
//  ADDR_W       11    requester address width
//  DATA_W       8     data width
//  MEM_AW       12    data_mem address width
//  MEM_BASE     8     first requester address mapped to data_mem word 0; lower addresses are out of range
//  STARVE_LIM   4     cycles a dbg request may lose to cpu before it is forced to win (1..15)
// PORTS
//  clk          in   1       system clock (the SoC drives cpu_clk here)
//  reset_       in   1       asynchronous, active-low reset
//  cpu_req      in   1       cpu access request (CPU m_en)
//  cpu_wr       in   1       1=write, 0=read
//  cpu_addr     in   ADDR_W  cpu address
//  cpu_wr_data  in   DATA_W  cpu write data
//  cpu_gnt      out  1       cpu access accepted this cycle; cpu must hold its request while low
//  cpu_rd_data  out  DATA_W  read data; valid only with cpu_rd_vld
//  cpu_rd_vld   out  1       1-cycle pulse, one cycle after a granted cpu read
//  dbg_req/dbg_wr/dbg_addr/dbg_wr_data                 same as the cpu_* inputs, debug port
//  dbg_lock     in   1       held with dbg_req to keep ownership across a burst
//  dbg_gnt/dbg_rd_data/dbg_rd_vld                      same as the cpu_* outputs, debug port
//  mem_addr     out  MEM_AW  data_mem address
//  mem_wr_data  out  DATA_W  data_mem write data
//  mem_wr       out  1       data_mem write strobe
//  mem_rd       out  1       data_mem read strobe
//  mem_rd_data  in   DATA_W  data_mem read data; 1-cycle synchronous latency
// BEHAVIOUR
//  - FSM states: IDLE, CPU, DBG, DBG_LOCK. State = owner of the previous cycle. Reset -> IDLE.
//  - At most one grant per cycle. Grants and mem_* are combinational from the requests and state,
//    so there is no added latency.
//  - Priority in IDLE/CPU/DBG: cpu wins, except when starve_cnt==STARVE_LIM and dbg_req=1; then dbg wins.
//  - DBG_LOCK: dbg wins every cycle while dbg_req=1. Exit to IDLE when dbg_req=0 or dbg_lock=0.
//    cpu_gnt=0 throughout; the cpu stalls.
//  - Transitions:
//    - cpu granted -> CPU
//    - dbg granted with dbg_lock=1 -> DBG_LOCK
//    - dbg granted with dbg_lock=0 -> DBG
//    - no request -> IDLE
//  - starve_cnt (4b): +1 when dbg_req=1 and dbg not granted, saturating at STARVE_LIM.
//    Cleared on any dbg grant or when dbg_req=0.
//  - Address: mem_addr = {addr - MEM_BASE} truncated to MEM_AW. If addr < MEM_BASE the access is still
//    granted, but mem_rd/mem_wr stay 0 and a read returns 0 with rd_vld.
//  - mem_rd = granted & ~wr & in-range; mem_wr = granted & wr & in-range.
//  - Read return: registered rd_owner (none/cpu/dbg) and oor flag. Next cycle, the owner's rd_vld=1 and
//    rd_data = oor ? 0 : mem_rd_data. The non-owner's rd_data is 0.
//  - Back-to-back reads from alternating owners are legal and return in order, one per cycle.
//  - Simultaneous cpu_req and dbg_req in the same cycle follow the priority rules above. Writes carry
//    no rd_vld.
//  - No grant: mem_addr and mem_wr_data = 0, mem_rd = mem_wr = 0.
//  - Reset (also asserted mid-burst or mid-read): state=IDLE, starve_cnt=0, rd_owner=none.
//    All outputs 0: gnt, rd_vld, rd_data, mem_* strobes. A pending read's rd_vld is dropped.
// CONFIGURATION
//  DMEM_ARB_RR_EN defined: in IDLE/CPU/DBG priority is round-robin. The requester that did not own the
//    last grant wins a tie (reset: cpu wins the first tie). The starvation override still applies.
//    DBG_LOCK is unchanged.
//  DMEM_ARB_RR_EN undefined: fixed cpu priority with the starvation override, as above.
// TESTING
//  1. Reset then cpu_req wr addr=9 data=8'hA5, then cpu read addr=9
//     -> mem_wr with mem_addr=1; next cycle cpu_rd_vld=1, cpu_rd_data=8'hA5.
//  2. cpu_req and dbg_req held continuously, STARVE_LIM=4, macro off
//     -> cpu_gnt for 4 cycles, dbg_gnt on the 5th, then the pattern repeats.
//  3. dbg burst: dbg_lock=1 for 6 writes at addr 8..13 with cpu_req=1
//     -> cpu_gnt=0 for all 6 cycles; cpu granted the cycle after dbg_lock drops.
//  4. cpu read at addr 3 (below MEM_BASE)
//     -> cpu_gnt=1, mem_rd=0; next cycle cpu_rd_vld=1, cpu_rd_data=8'h00.
//  5. Alternate cpu read addr 8 and dbg read addr 9 (mem holds 8'h11 and 8'h22)
//     -> rd_vld pulses alternate; cpu gets 8'h11, dbg gets 8'h22.
//  6. reset_ low during a DBG_LOCK read -> all outputs 0 immediately, no rd_vld after release;
//     with DMEM_ARB_RR_EN, test 2 yields alternating grants.

Source files
------------

// File: rtl/dmem_arbiter.sv
// Two-requester arbiter (cpu, debug) in front of the single-port synchronous data_mem.
// Define DMEM_ARB_RR_EN for round-robin tie-breaking instead of fixed cpu priority.
module dmem_arbiter #(
  parameter int unsigned ADDR_W     = 11,
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned MEM_AW     = 12,
  parameter int unsigned MEM_BASE   = 8,
  parameter int unsigned STARVE_LIM = 4
) (
  input  logic              clk,
  input  logic              reset_,
  input  logic              cpu_req,
  input  logic              cpu_wr,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wr_data,
  output logic              cpu_gnt,
  output logic [DATA_W-1:0] cpu_rd_data,
  output logic              cpu_rd_vld,
  input  logic              dbg_req,
  input  logic              dbg_wr,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wr_data,
  input  logic              dbg_lock,
  output logic              dbg_gnt,
  output logic [DATA_W-1:0] dbg_rd_data,
  output logic              dbg_rd_vld,
  output logic [MEM_AW-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wr_data,
  output logic              mem_wr,
  output logic              mem_rd,
  input  logic [DATA_W-1:0] mem_rd_data
);

  localparam logic [3:0]        LIM  = 4'(STARVE_LIM);
  localparam logic [ADDR_W-1:0] BASE = ADDR_W'(MEM_BASE);

  typedef enum logic [1:0] {ST_IDLE, ST_CPU, ST_DBG, ST_DBG_LOCK} state_e;
  typedef enum logic [1:0] {OWN_NONE, OWN_CPU, OWN_DBG} owner_e;

  state_e            state_q, state_d;
  owner_e            owner_q, owner_d;
  logic [3:0]        starve_q, starve_d;
  logic              oor_q, oor_d;
  logic              gnt_cpu_c, gnt_dbg_c, granted_c, in_range_c;
  logic              sel_wr_c;
  logic [ADDR_W-1:0] sel_addr_c;
  logic [DATA_W-1:0] sel_data_c;
`ifdef DMEM_ARB_RR_EN
  logic              last_dbg_q, last_dbg_d;
`endif

  // Grant decision: lock ownership first, then starvation override, then tie-break.
  always_comb begin
    gnt_cpu_c = 1'b0;
    gnt_dbg_c = 1'b0;
    if (state_q == ST_DBG_LOCK && dbg_req && dbg_lock) begin
      gnt_dbg_c = 1'b1;
    end else if (dbg_req && starve_q == LIM) begin
      gnt_dbg_c = 1'b1;
    end else if (cpu_req && dbg_req) begin
`ifdef DMEM_ARB_RR_EN
      gnt_cpu_c = last_dbg_q;
      gnt_dbg_c = ~last_dbg_q;
`else
      gnt_cpu_c = 1'b1;
`endif
    end else if (cpu_req) begin
      gnt_cpu_c = 1'b1;
    end else if (dbg_req) begin
      gnt_dbg_c = 1'b1;
    end
    if (!reset_) begin
      gnt_cpu_c = 1'b0;
      gnt_dbg_c = 1'b0;
    end
  end

  always_comb begin
    granted_c  = gnt_cpu_c | gnt_dbg_c;
    sel_wr_c   = gnt_dbg_c ? dbg_wr      : cpu_wr;
    sel_addr_c = gnt_dbg_c ? dbg_addr    : cpu_addr;
    sel_data_c = gnt_dbg_c ? dbg_wr_data : cpu_wr_data;
    in_range_c = (sel_addr_c >= BASE);
  end

  // Memory side: out-of-range accesses are granted but never strobe the array.
  always_comb begin
    cpu_gnt     = gnt_cpu_c;
    dbg_gnt     = gnt_dbg_c;
    mem_addr    = granted_c ? MEM_AW'(sel_addr_c - BASE) : '0;
    mem_wr_data = granted_c ? sel_data_c : '0;
    mem_rd      = granted_c & ~sel_wr_c & in_range_c;
    mem_wr      = granted_c &  sel_wr_c & in_range_c;
  end

  always_comb begin
    state_d  = ST_IDLE;
    owner_d  = OWN_NONE;
    oor_d    = 1'b0;
    starve_d = starve_q;
    if (gnt_cpu_c) begin
      state_d = ST_CPU;
    end else if (gnt_dbg_c) begin
      state_d = dbg_lock ? ST_DBG_LOCK : ST_DBG;
    end
    if (granted_c && !sel_wr_c) begin
      owner_d = gnt_dbg_c ? OWN_DBG : OWN_CPU;
      oor_d   = ~in_range_c;
    end
    if (!dbg_req || gnt_dbg_c) begin
      starve_d = 4'd0;
    end else if (starve_q != LIM) begin
      starve_d = starve_q + 4'd1;
    end
  end

`ifdef DMEM_ARB_RR_EN
  always_comb begin
    last_dbg_d = last_dbg_q;
    if (granted_c) last_dbg_d = gnt_dbg_c;
  end

  // Reset pretends dbg owned the last grant so cpu wins the first tie.
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) last_dbg_q <= 1'b1;
    else         last_dbg_q <= last_dbg_d;
  end
`endif

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      state_q  <= ST_IDLE;
      owner_q  <= OWN_NONE;
      starve_q <= 4'd0;
      oor_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      starve_q <= starve_d;
      oor_q    <= oor_d;
    end
  end

  // Read return: the registered owner steers the memory's one-cycle-late data.
  always_comb begin
    cpu_rd_vld  = (owner_q == OWN_CPU);
    dbg_rd_vld  = (owner_q == OWN_DBG);
    cpu_rd_data = (cpu_rd_vld && !oor_q) ? mem_rd_data : '0;
    dbg_rd_data = (dbg_rd_vld && !oor_q) ? mem_rd_data : '0;
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Randomized scoreboard bench for dmem_arbiter with a behavioural arbitration/memory model.
module tb_dmem_arbiter;

  localparam int LIM = 4;

  logic        clk, reset_;
  logic        cpu_req, cpu_wr, dbg_req, dbg_wr, dbg_lock;
  logic [10:0] cpu_addr, dbg_addr;
  logic [7:0]  cpu_wr_data, dbg_wr_data;
  logic        cpu_gnt, cpu_rd_vld, dbg_gnt, dbg_rd_vld;
  logic [7:0]  cpu_rd_data, dbg_rd_data, mem_wr_data, mem_rd_data;
  logic [11:0] mem_addr;
  logic        mem_wr, mem_rd;

  dmem_arbiter dut (
    .clk(clk), .reset_(reset_),
    .cpu_req(cpu_req), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr), .cpu_wr_data(cpu_wr_data),
    .cpu_gnt(cpu_gnt), .cpu_rd_data(cpu_rd_data), .cpu_rd_vld(cpu_rd_vld),
    .dbg_req(dbg_req), .dbg_wr(dbg_wr), .dbg_addr(dbg_addr), .dbg_wr_data(dbg_wr_data),
    .dbg_lock(dbg_lock), .dbg_gnt(dbg_gnt), .dbg_rd_data(dbg_rd_data), .dbg_rd_vld(dbg_rd_vld),
    .mem_addr(mem_addr), .mem_wr_data(mem_wr_data), .mem_wr(mem_wr), .mem_rd(mem_rd),
    .mem_rd_data(mem_rd_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] pat(int i);
    return 8'(i * 7 + 3);
  endfunction

  // data_mem stand-in: synchronous, one cycle read latency, unwritten words hold pat().
  bit [7:0] mem_arr [4096];
  bit       mem_wrt [4096];
  always @(posedge clk) begin
    if (mem_rd) mem_rd_data <= mem_wrt[mem_addr] ? mem_arr[mem_addr] : pat(int'(mem_addr));
    if (mem_wr) begin
      mem_arr[mem_addr] <= mem_wr_data;
      mem_wrt[mem_addr] <= 1'b1;
    end
  end

  // Reference model state, kept in requester address space.
  bit [7:0] ref_mem [2048];
  bit       ref_wrt [2048];
  int       starve;
  bit       locked;
  bit       last_dbg;
  logic [8:0] expq [$];
  int       n_chk, n_fail;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int predict(bit cr, bit dr, bit dl);
    if (locked && dr && dl) return 2;
    if (dr && starve == LIM) return 2;
    if (cr && dr) begin
`ifdef DMEM_ARB_RR_EN
      return last_dbg ? 1 : 2;
`else
      return 1;
`endif
    end
    if (cr) return 1;
    if (dr) return 2;
    return 0;
  endfunction

  function automatic logic [7:0] exp_rd(logic [10:0] a);
    if (a < 11'd8) return 8'h00;
    return ref_wrt[a] ? ref_mem[a] : pat(int'(a) - 8);
  endfunction

  task automatic model_reset();
    starve = 0; locked = 1'b0; last_dbg = 1'b1;
    expq.delete();
  endtask

  // One bus cycle: drive, check the combinational grant/memory side, queue the expected read.
  task automatic cycle(input logic cr, input logic cw, input logic [10:0] ca, input logic [7:0] cd,
                       input logic dr, input logic dw, input logic [10:0] da, input logic [7:0] dd,
                       input logic dl, output int win);
    logic [10:0] a; logic w; logic [7:0] d; logic inr; logic g;
    @(posedge clk); #1;
    cpu_req = cr; cpu_wr = cw; cpu_addr = ca; cpu_wr_data = cd;
    dbg_req = dr; dbg_wr = dw; dbg_addr = da; dbg_wr_data = dd; dbg_lock = dl;
    @(negedge clk); #1;
    win = predict(cr, dr, dl);
    a = (win == 2) ? da : ca;
    w = (win == 2) ? dw : cw;
    d = (win == 2) ? dd : cd;
    g = (win != 0);
    inr = (a >= 11'd8);
    chk("cpu_gnt", 32'(cpu_gnt), 32'(win == 1));
    chk("dbg_gnt", 32'(dbg_gnt), 32'(win == 2));
    chk("rd_pending", 32'(expq.size()), 32'd0);
    expq.delete();
    chk("mem_rd", 32'(mem_rd), 32'(g && !w && inr));
    chk("mem_wr", 32'(mem_wr), 32'(g && w && inr));
    if (g && inr) chk("mem_addr", 32'(mem_addr), 32'(a - 11'd8));
    if (g && w && inr) chk("mem_wr_data", 32'(mem_wr_data), 32'(d));
    if (!g) chk("mem_addr_idle", 32'(mem_addr), 32'd0);
    if (g && !w) expq.push_back({win == 2, exp_rd(a)});
    if (g && w && inr) begin
      ref_mem[a] = d;
      ref_wrt[a] = 1'b1;
    end
    if (dr && win != 2) starve = (starve < LIM) ? starve + 1 : LIM;
    else starve = 0;
    locked = (win == 2) && dl;
    if (g) last_dbg = (win == 2);
  endtask

  task automatic idle(input int n);
    int w;
    for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, w);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_gnt"},    32'({cpu_gnt, dbg_gnt}), 32'd0);
    chk({tag, "_strobe"}, 32'({mem_rd, mem_wr}), 32'd0);
    chk({tag, "_vld"},    32'({cpu_rd_vld, dbg_rd_vld}), 32'd0);
    chk({tag, "_rdata"},  32'({cpu_rd_data, dbg_rd_data}), 32'd0);
    chk({tag, "_maddr"},  32'(mem_addr), 32'd0);
  endtask

  initial begin
    int w, prev;
    bit cpu_done, dbg_done;
    logic cr, cw, dr, dw, dl;
    logic [10:0] ca, da;
    logic [7:0] cd, dd;

    n_chk = 0; n_fail = 0;
    model_reset();
    reset_ = 1'b0;
    cpu_req = 1'b1; cpu_wr = 1'b0; cpu_addr = 11'd9; cpu_wr_data = 8'h00;
    dbg_req = 1'b1; dbg_wr = 1'b0; dbg_addr = 11'd10; dbg_wr_data = 8'h00; dbg_lock = 1'b1;
    mem_rd_data = 8'h5A;

    fork
      begin : monitor
        logic [8:0] e;
        forever begin
          @(negedge clk);
          if (reset_ && (cpu_rd_vld || dbg_rd_vld)) begin
            if (expq.size() == 0) begin
              n_chk++; n_fail++;
              $display("FAIL rd_unexpected: cpu_vld=%0b dbg_vld=%0b, expected none", cpu_rd_vld, dbg_rd_vld);
            end else begin
              e = expq.pop_front();
              chk("rd_owner", 32'({dbg_rd_vld, cpu_rd_vld}), e[8] ? 32'd2 : 32'd1);
              chk("rd_data", 32'(e[8] ? dbg_rd_data : cpu_rd_data), 32'(e[7:0]));
              chk("rd_data_other", 32'(e[8] ? cpu_rd_data : dbg_rd_data), 32'd0);
            end
          end
        end
      end
    join_none

    // Held in reset with both requests up: everything stays quiet.
    #12;
    chk_all_zero("reset");
    cpu_req = 1'b0; dbg_req = 1'b0; dbg_lock = 1'b0;
    #11 reset_ = 1'b1;

    // Write then read back through the base offset.
    cycle(1, 1, 11'd9, 8'hA5, 0, 0, 0, 0, 0, w);
    cycle(1, 0, 11'd9, 8'h00, 0, 0, 0, 0, 0, w);
    idle(2);

    // Both held: starvation override (or alternation with round-robin).
    prev = 0;
    for (int i = 0; i < 15; i++) begin
      cycle(1, 0, 11'd20, 8'h00, 1, 0, 11'd21, 8'h00, 0, w);
`ifdef DMEM_ARB_RR_EN
      if (i > 0) chk("rr_alternate", 32'(w), (prev == 1) ? 32'd2 : 32'd1);
`else
      chk("starve_pattern", 32'(w), (i % 5 == 4) ? 32'd2 : 32'd1);
`endif
      prev = w;
    end
    idle(2);

    // Locked debug burst stalls a waiting cpu; cpu wins once the lock is released.
    cycle(0, 0, 0, 0, 1, 1, 11'd8, 8'hC0, 1, w);
    chk("lock_start", 32'(w), 32'd2);
    for (int k = 1; k < 6; k++) begin
      cycle(1, 0, 11'd8, 8'h00, 1, 1, 11'(8 + k), 8'(8'hC0 + k), 1, w);
      chk("lock_cpu_stall", 32'(w), 32'd2);
    end
    cycle(1, 0, 11'd8, 8'h00, 0, 0, 0, 0, 0, w);
    chk("cpu_after_lock", 32'(w), 32'd1);
    idle(1);

    // Below MEM_BASE: granted, no strobe, zero read data.
    cycle(1, 0, 11'd3, 8'h00, 0, 0, 0, 0, 0, w);
    chk("oor_gnt", 32'(w), 32'd1);
    idle(1);

    // Alternating back-to-back reads from both owners.
    cycle(0, 0, 0, 0, 1, 1, 11'd8, 8'h11, 0, w);
    cycle(0, 0, 0, 0, 1, 1, 11'd9, 8'h22, 0, w);
    for (int k = 0; k < 4; k++) begin
      cycle(1, 0, 11'd8, 8'h00, 0, 0, 0, 0, 0, w);
      cycle(0, 0, 0, 0, 1, 0, 11'd9, 8'h00, 0, w);
    end
    idle(1);

    // Randomized traffic; a requester holds its transaction until granted.
    cpu_done = 1'b1; dbg_done = 1'b1;
    cr = 0; cw = 0; ca = 0; cd = 0; dr = 0; dw = 0; da = 0; dd = 0; dl = 0;
    for (int i = 0; i < 3000; i++) begin
      if (cpu_done) begin
        cr = ($urandom_range(0, 9) < 6);
        cw = 1'($urandom_range(0, 1));
        ca = ($urandom_range(0, 7) == 0) ? 11'($urandom) : 11'($urandom_range(0, 23));
        cd = 8'($urandom);
      end
      if (dbg_done) begin
        dr = locked ? ($urandom_range(0, 9) < 9) : ($urandom_range(0, 9) < 5);
        dl = locked ? ($urandom_range(0, 9) < 8) : ($urandom_range(0, 9) < 2);
        dw = 1'($urandom_range(0, 1));
        da = ($urandom_range(0, 7) == 0) ? 11'($urandom) : 11'($urandom_range(0, 23));
        dd = 8'($urandom);
      end
      cycle(cr, cw, ca, cd, dr, dw, da, dd, dl, w);
      cpu_done = !cr || (w == 1);
      dbg_done = !dr || (w == 2);
    end
    idle(2);

    // Reset in the middle of a locked read: immediate silence, the pending read is dropped.
    cycle(0, 0, 0, 0, 1, 0, 11'd8, 8'h00, 1, w);
    @(posedge clk); #1;
    cpu_req = 1'b1; cpu_wr = 1'b0; cpu_addr = 11'd10;
    dbg_req = 1'b1; dbg_wr = 1'b0; dbg_addr = 11'd9; dbg_lock = 1'b1;
    #2 reset_ = 1'b0;
    #1;
    chk_all_zero("midrst");
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    cpu_req = 1'b0; dbg_req = 1'b0; dbg_lock = 1'b0;
    #2 reset_ = 1'b1;
    idle(1);
    chk("post_rst_vld", 32'({cpu_rd_vld, dbg_rd_vld}), 32'd0);
    idle(3);
    cycle(1, 0, 11'd9, 8'h00, 0, 0, 0, 0, 0, w);
    chk("post_rst_gnt", 32'(w), 32'd1);
    idle(2);
    chk("queue_empty", 32'(expq.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
